// File: rtl/ct_hpcp_pkg.sv
// ct_hpcp_pkg: shared hpcp counter-overflow constants and write FSM encoding
package ct_hpcp_pkg;
  localparam int HPCP_NUM_CNT = 32;
  typedef enum logic [1:0] {
    CNTOF_IDLE    = 2'd0,
    CNTOF_WAIT_L2 = 2'd1,
    CNTOF_COMMIT  = 2'd2
  } cntof_st_e;
endpackage

// File: rtl/ct_hpcp_rr_sel.sv
// ct_hpcp_rr_sel: round-robin find-first set bit at or after ptr, wrapping to bit 0
module ct_hpcp_rr_sel #(
  parameter int N = 32,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    vld = |req;
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/ct_hpcp_cntof_ctrl.sv
// ct_hpcp_cntof_ctrl: overflow sticky write sequencing behind L2 retire, plus round-robin overflow interrupt arbiter
module ct_hpcp_cntof_ctrl
  import ct_hpcp_pkg::*;
#(
  parameter int NUM_CNT = HPCP_NUM_CNT,
  localparam int IW = $clog2(NUM_CNT)
) (
  input  logic               hpcp_clk,
  input  logic               cpurst_b,
  input  logic               csr_wr_vld,
  input  logic [NUM_CNT-1:0] csr_wr_data,
  output logic               csr_wr_rdy,
  input  logic               l2cnt_wr_done,
  output logic [NUM_CNT-1:0] cntof_wen,
  output logic [NUM_CNT-1:0] cntof_wdata,
  output logic               l2cnt_cmplt_ff,
  input  logic [NUM_CNT-1:0] cntof,
  input  logic [NUM_CNT-1:0] ovf_inten,
  output logic               hpcp_int_req,
  output logic [IW-1:0]      hpcp_int_idx,
  input  logic               hpcp_int_ack
);
  cntof_st_e     st;
  logic [IW-1:0] ptr;
  logic          sel_vld;
  logic [IW-1:0] sel_idx;
  ct_hpcp_rr_sel #(.N(NUM_CNT)) u_rr_sel (
    .req (cntof & ovf_inten),
    .ptr (ptr),
    .vld (sel_vld),
    .idx (sel_idx)
  );
  assign csr_wr_rdy = st == CNTOF_IDLE;
  always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      st             <= CNTOF_IDLE;
      cntof_wen      <= '0;
      cntof_wdata    <= '0;
      l2cnt_cmplt_ff <= 1'b0;
      hpcp_int_req   <= 1'b0;
      hpcp_int_idx   <= '0;
      ptr            <= '0;
    end else begin
      case (st)
        CNTOF_IDLE: if (csr_wr_vld) begin
          st          <= CNTOF_WAIT_L2;
          cntof_wdata <= csr_wr_data;
          cntof_wen   <= '1;
        end
        CNTOF_WAIT_L2: if (l2cnt_wr_done) begin
          st             <= CNTOF_COMMIT;
          l2cnt_cmplt_ff <= 1'b1;
        end
        default: begin
          st             <= CNTOF_IDLE;
          cntof_wen      <= '0;
          l2cnt_cmplt_ff <= 1'b0;
        end
      endcase
      // pending still shows pre-write bits during COMMIT, so hold off launching
      if (hpcp_int_req) begin
        if (hpcp_int_ack) begin
          hpcp_int_req <= 1'b0;
          ptr          <= hpcp_int_idx == IW'(NUM_CNT - 1) ? '0 : hpcp_int_idx + 1'b1;
        end
      end else if (sel_vld && st != CNTOF_COMMIT) begin
        hpcp_int_req <= 1'b1;
        hpcp_int_idx <= sel_idx;
      end
    end
  end
endmodule

// File: tb/tb_ct_hpcp_cntof_ctrl.sv
// tb_ct_hpcp_cntof_ctrl: table vectors, directed corner sequences and random traffic against a transaction-level model
module tb_ct_hpcp_cntof_ctrl;
  localparam int N = 32;
  localparam int IW = 5;
  logic          hpcp_clk = 1'b0;
  logic          cpurst_b = 1'b0;
  logic          csr_wr_vld = 1'b0;
  logic [N-1:0]  csr_wr_data = '0;
  logic          csr_wr_rdy;
  logic          l2cnt_wr_done = 1'b0;
  logic [N-1:0]  cntof_wen, cntof_wdata;
  logic          l2cnt_cmplt_ff;
  logic [N-1:0]  cntof = '0;
  logic [N-1:0]  ovf_inten = '0;
  logic          hpcp_int_req;
  logic [IW-1:0] hpcp_int_idx;
  logic          hpcp_int_ack = 1'b0;
  int checks = 0;
  int errors = 0;
  bit m_busy, m_cmt, m_req;
  logic [N-1:0] m_wdata;
  int m_idx, m_ptr;

  typedef struct {
    bit vld; logic [N-1:0] data; bit done;
    bit rdy; bit wen; bit cmplt; logic [N-1:0] wdata;
  } vec_t;
  vec_t tbl [10];

  always #5 hpcp_clk = ~hpcp_clk;

  ct_hpcp_cntof_ctrl #(.NUM_CNT(N)) dut (
    .hpcp_clk       (hpcp_clk),
    .cpurst_b       (cpurst_b),
    .csr_wr_vld     (csr_wr_vld),
    .csr_wr_data    (csr_wr_data),
    .csr_wr_rdy     (csr_wr_rdy),
    .l2cnt_wr_done  (l2cnt_wr_done),
    .cntof_wen      (cntof_wen),
    .cntof_wdata    (cntof_wdata),
    .l2cnt_cmplt_ff (l2cnt_cmplt_ff),
    .cntof          (cntof),
    .ovf_inten      (ovf_inten),
    .hpcp_int_req   (hpcp_int_req),
    .hpcp_int_idx   (hpcp_int_idx),
    .hpcp_int_ack   (hpcp_int_ack)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr(logic [N-1:0] p, int ptr);
    for (int k = 0; k < N; k++) if (p[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_cmt = 0; m_req = 0; m_wdata = '0; m_idx = 0; m_ptr = 0;
  endfunction

  // one clock: advance the model from pre-edge inputs, let the sticky register absorb a committed write, compare
  task automatic step();
    logic [N-1:0] pend, wn, wd;
    int sel;
    bit was_cmt, commit;
    pend = cntof & ovf_inten;
    sel = rr(pend, m_ptr);
    was_cmt = m_cmt;
    commit = l2cnt_cmplt_ff;
    wn = cntof_wen;
    wd = cntof_wdata;
    if (m_cmt) m_cmt = 0;
    else if (m_busy) begin
      if (l2cnt_wr_done) begin m_busy = 0; m_cmt = 1; end
    end else if (csr_wr_vld) begin
      m_busy = 1; m_wdata = csr_wr_data;
    end
    if (m_req) begin
      if (hpcp_int_ack) begin m_req = 0; m_ptr = (m_idx + 1) % N; end
    end else if (sel >= 0 && !was_cmt) begin
      m_req = 1; m_idx = sel;
    end
    @(posedge hpcp_clk);
    #1;
    if (commit) cntof = (cntof & ~wn) | (wd & wn);
    l2cnt_wr_done = 1'b0;
    hpcp_int_ack = 1'b0;
    chk("rdy", csr_wr_rdy, !(m_busy || m_cmt));
    chk("wen", cntof_wen, (m_busy || m_cmt) ? {N{1'b1}} : '0);
    chk("wdata", cntof_wdata, m_wdata);
    chk("cmplt", l2cnt_cmplt_ff, m_cmt);
    chk("req", hpcp_int_req, m_req);
    chk("idx", hpcp_int_idx, m_idx);
  endtask

  task automatic do_reset();
    #2 cpurst_b = 1'b0;
    #1;
    model_reset();
    chk("rst_wen", cntof_wen, 0);
    chk("rst_wdata", cntof_wdata, 0);
    chk("rst_cmplt", l2cnt_cmplt_ff, 0);
    chk("rst_req", hpcp_int_req, 0);
    chk("rst_idx", hpcp_int_idx, 0);
    @(posedge hpcp_clk);
    #1 cpurst_b = 1'b1;
    chk("rst_rdy", csr_wr_rdy, 1);
  endtask

  task automatic csr_write(logic [N-1:0] d);
    csr_wr_vld = 1'b1; csr_wr_data = d;
    step();
    csr_wr_vld = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1, 32'hF0, 0, 0, 1, 0, 32'hF0};
    tbl[1] = '{1, 32'hAA, 0, 0, 1, 0, 32'hF0};
    tbl[2] = '{1, 32'hAA, 0, 0, 1, 0, 32'hF0};
    tbl[3] = '{1, 32'hAA, 1, 0, 1, 1, 32'hF0};
    tbl[4] = '{1, 32'hAA, 0, 1, 0, 0, 32'hF0};
    tbl[5] = '{1, 32'hAA, 0, 0, 1, 0, 32'hAA};
    tbl[6] = '{0, 32'h00, 0, 0, 1, 0, 32'hAA};
    tbl[7] = '{0, 32'h00, 1, 0, 1, 1, 32'hAA};
    tbl[8] = '{0, 32'h00, 1, 1, 0, 0, 32'hAA};
    tbl[9] = '{0, 32'h00, 1, 1, 0, 0, 32'hAA};
    do_reset();
    for (int r = 0; r < 10; r++) begin
      csr_wr_vld = tbl[r].vld; csr_wr_data = tbl[r].data; l2cnt_wr_done = tbl[r].done;
      step();
      chk("tbl_rdy", csr_wr_rdy, tbl[r].rdy);
      chk("tbl_wen", cntof_wen, {N{tbl[r].wen}});
      chk("tbl_cmplt", l2cnt_cmplt_ff, tbl[r].cmplt);
      chk("tbl_wdata", cntof_wdata, tbl[r].wdata);
    end
    csr_wr_vld = 1'b0;
    chk("tbl_sticky", cntof, 32'hAA);
    // round-robin order with wrap
    do_reset();
    cntof = 32'h9; ovf_inten = 32'hF;
    step();
    chk("rr_first", {hpcp_int_req, 27'd0, hpcp_int_idx}, {1'b1, 27'd0, 5'd0});
    hpcp_int_ack = 1'b1; step();
    chk("rr_ackdrop", hpcp_int_req, 0);
    step();
    chk("rr_second", hpcp_int_idx, 3);
    hpcp_int_ack = 1'b1; step(); step();
    chk("rr_wrap", {hpcp_int_req, 27'd0, hpcp_int_idx}, {1'b1, 27'd0, 5'd0});
    // pending bit 0 cleared by a write while its request is outstanding
    csr_write(32'h8);
    l2cnt_wr_done = 1'b1; step(); step();
    chk("hold_sticky", cntof, 32'h8);
    chk("hold_req", hpcp_int_req, 1);
    chk("hold_idx", hpcp_int_idx, 0);
    hpcp_int_ack = 1'b1; step(); step();
    chk("hold_next", hpcp_int_idx, 3);
    // no launch in the COMMIT cycle, resume once the write lands
    csr_write(32'h2);
    l2cnt_wr_done = 1'b1; hpcp_int_ack = 1'b1; step();
    step();
    chk("cmt_block", hpcp_int_req, 0);
    step();
    chk("cmt_resume", {hpcp_int_req, 27'd0, hpcp_int_idx}, {1'b1, 27'd0, 5'd1});
    // only bit 31 pending with pointer at 5
    do_reset();
    ovf_inten = '1; cntof = 32'h10;
    step();
    chk("b31_pre", hpcp_int_idx, 4);
    cntof = 32'h8000_0000;
    hpcp_int_ack = 1'b1; step(); step();
    chk("b31_idx", {hpcp_int_req, 27'd0, hpcp_int_idx}, {1'b1, 27'd0, 5'd31});
    cntof = 32'h8000_0001;
    hpcp_int_ack = 1'b1; step(); step();
    chk("b31_wrap", hpcp_int_idx, 0);
    // reset while waiting for L2 aborts the write
    do_reset();
    ovf_inten = '0; cntof = 32'h55;
    csr_write(32'hFF);
    step();
    #2 cpurst_b = 1'b0;
    #1 model_reset();
    chk("abort_wen", cntof_wen, 0);
    @(posedge hpcp_clk);
    #1 cpurst_b = 1'b1;
    l2cnt_wr_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_cmplt", l2cnt_cmplt_ff, 0);
    end
    chk("abort_sticky", cntof, 32'h55);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      csr_wr_vld = ($urandom % 3) == 0;
      csr_wr_data = $urandom;
      l2cnt_wr_done = ($urandom % 4) == 0;
      hpcp_int_ack = hpcp_int_req ? ($urandom % 3) == 0 : ($urandom % 5) == 0;
      if (($urandom % 8) == 0) cntof[$urandom % N] = 1'b1;
      if (($urandom % 50) == 0) ovf_inten = $urandom;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
